fp_mul_round_norm: RTL and testbench

- Downstream stage of the single-precision FP multiplier.
- Consumes the 50-bit mantissa product from the 26x24 Wallace product stage, plus sign, exponent sum and special-operand flags.
- Normalises, rounds to nearest-even, handles overflow/underflow/specials, and emits a packed IEEE-754 single.
- Two-stage pipeline with valid/ready backpressure, feeding the FPU result mux.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_round_rne.sv | 23 ++
 rtl/fp_mul_round_norm.sv | 126 ++++++++++++
 tb/tb_fp_mul_round_norm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP constants, flag bit positions and the stage-1 payload layout
// used by the multiplier back end.
package fp_pkg;
   localparam int          FP_BIAS    = 127;
   localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
   localparam int          FP_EXP_MAX = 255;

   // Bit positions inside the 4-bit flags vector {inv, ovf, unf, inx}
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   // Normalised product held between the two pipeline stages
   typedef struct packed {
      logic [22:0]        m;     // fraction bits below the hidden one
      logic               g;     // guard bit
      logic               s;     // sticky OR of everything below guard
      logic signed [10:0] e;     // unbiased-then-rebiased exponent, may be <=0 or >=255
      logic               sign;
      logic               zero;
      logic               inf;
      logic               nan;
   } s1_t;
endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 23-bit fraction with guard/sticky; a rounding
// carry out of the fraction bumps the exponent and clears the fraction.
module fp_round_rne
   import fp_pkg::*;
(
   input  logic [22:0]        i_m,
   input  logic               i_g,
   input  logic               i_s,
   input  logic signed [10:0] i_e,
   output logic [22:0]        o_mant,
   output logic signed [10:0] o_exp,
   output logic               o_inexact
);
   logic        w_up;
   logic [23:0] w_mr;

   // Increment when above half, or exactly half with an odd LSB
   assign w_up      = i_g & (i_s | i_m[0]);
   assign w_mr      = {1'b0, i_m} + {23'd0, w_up};
   assign o_mant    = w_mr[23] ? 23'd0 : w_mr[22:0];
   assign o_exp     = i_e + $signed({10'd0, w_mr[23]});
   assign o_inexact = i_g | i_s;
endmodule

// File: rtl/fp_mul_round_norm.sv
// Back end of the single-precision multiplier: normalise the 50-bit product,
// round to nearest-even, resolve specials/overflow/underflow and pack the
// IEEE single. Two register stages with valid/ready; no skid buffer.
module fp_mul_round_norm
   import fp_pkg::*;
#(
   parameter int BIAS   = FP_BIAS,
   parameter int PROD_W = 50
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   input  logic              sign,
   input  logic [9:0]        exp_sum,
   input  logic              op_zero,
   input  logic              op_inf,
   input  logic              op_nan,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       result,
   output logic [3:0]        flags
);
   logic               w_en1, w_en2;
   s1_t                w_s1_nxt;
   s1_t                r_s1;
   logic               r_s1_valid;
   logic               r_out_valid;
   logic [31:0]        r_result;
   logic [3:0]         r_flags;
   logic [22:0]        w_rnd_mant;
   logic signed [10:0] w_rnd_exp;
   logic               w_rnd_inx;
   logic [31:0]        w_res;
   logic [3:0]         w_flg;
   logic               w_hi;

   // Stage 2 advances when empty or drained; stage 1 when empty or stage 2 moves
   assign w_en2    = !r_out_valid | out_ready;
   assign w_en1    = !r_s1_valid | w_en2;
   assign in_ready = w_en1;

   assign out_valid = r_out_valid;
   assign result    = r_result;
   assign flags     = r_flags;

   // Normalise: a product in [2,4) shifts one further and bumps the exponent
   assign w_hi = prod[PROD_W-1];
   always_comb begin
      w_s1_nxt      = '0;
      w_s1_nxt.m    = w_hi ? prod[48:26] : prod[47:25];
      w_s1_nxt.g    = w_hi ? prod[25]    : prod[24];
      w_s1_nxt.s    = w_hi ? (|prod[24:0]) : (|prod[23:0]);
      w_s1_nxt.e    = $signed({1'b0, exp_sum} - 11'(BIAS) + {10'd0, w_hi});
      w_s1_nxt.sign = sign;
      w_s1_nxt.zero = op_zero;
      w_s1_nxt.inf  = op_inf;
      w_s1_nxt.nan  = op_nan;
   end

   // Stage 1 register: payload only captured for real transfers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1       <= '0;
      end else if (w_en1) begin
         r_s1_valid <= in_valid;
         if (in_valid) r_s1 <= w_s1_nxt;
      end
   end

   fp_round_rne u_rnd (
      .i_m       (r_s1.m),
      .i_g       (r_s1.g),
      .i_s       (r_s1.s),
      .i_e       (r_s1.e),
      .o_mant    (w_rnd_mant),
      .o_exp     (w_rnd_exp),
      .o_inexact (w_rnd_inx)
   );

   // Result selection; underflow looks at the pre-rounding exponent so a
   // carry out of e=0 still flushes, overflow looks at the rounded one
   always_comb begin
      w_res          = {r_s1.sign, w_rnd_exp[7:0], w_rnd_mant};
      w_flg          = '0;
      w_flg[FLG_INX] = w_rnd_inx;
      if (r_s1.nan | (r_s1.inf & r_s1.zero)) begin
         w_res          = FP_QNAN;
         w_flg          = '0;
         w_flg[FLG_INV] = r_s1.inf & r_s1.zero;
      end else if (r_s1.inf) begin
         w_res = {r_s1.sign, 8'hFF, 23'd0};
         w_flg = '0;
      end else if (r_s1.zero) begin
         w_res = {r_s1.sign, 31'd0};
         w_flg = '0;
      end else if (w_rnd_exp >= $signed(11'(FP_EXP_MAX))) begin
         w_res          = {r_s1.sign, 8'hFF, 23'd0};
         w_flg          = '0;
         w_flg[FLG_OVF] = 1'b1;
         w_flg[FLG_INX] = 1'b1;
      end else if ($signed(r_s1.e) <= 11'sd0) begin
         w_res          = {r_s1.sign, 31'd0};
         w_flg          = '0;
         w_flg[FLG_UNF] = 1'b1;
         w_flg[FLG_INX] = 1'b1;
      end
   end

   // Stage 2 register: output holds while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
      end else if (w_en2) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result <= w_res;
            r_flags  <= w_flg;
         end
      end
   end
endmodule

// File: tb/tb_fp_mul_round_norm.sv
// Bench for the multiplier back end: directed corner cases with fixed
// expectations, backpressure and reset scenarios, then randomized traffic
// scored against an arithmetic reference model.
module tb_fp_mul_round_norm;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready;
   logic [49:0] prod;
   logic        sign;
   logic [9:0]  exp_sum;
   logic        op_zero, op_inf, op_nan;
   logic        out_valid, out_ready;
   logic [31:0] result;
   logic [3:0]  flags;

   int n_tot = 0;
   int n_bad = 0;
   logic [35:0] q[$];
   logic [35:0] mon_e;
   logic [31:0] held;

   fp_mul_round_norm dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .prod(prod), .sign(sign), .exp_sum(exp_sum), .op_zero(op_zero),
      .op_inf(op_inf), .op_nan(op_nan), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flags(flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h", tag, act, exp);
      end
   endtask

   // Reference: value = prod/2^48; keep 24 significant bits, round the
   // discarded remainder to nearest-even, then apply the special/range rules.
   function automatic logic [35:0] model(input logic [49:0] p, input logic sg,
                                         input logic [9:0] es, input logic z,
                                         input logic i, input logic n);
      longint unsigned pv, keep, rem, half;
      int sh, e, epre;
      logic [31:0] r;
      logic [3:0]  f;
      pv   = 64'(p);
      sh   = p[49] ? 26 : 25;
      keep = pv >> sh;
      rem  = pv - (keep << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && (keep % 2) == 1)) keep = keep + 1;
      epre = int'(es) - 127 + (p[49] ? 1 : 0);
      e    = epre;
      if (keep == (64'd1 << 24)) begin
         e    = e + 1;
         keep = 64'd1 << 23;
      end
      f = {3'b000, rem != 0};
      r = {sg, 8'(e), keep[22:0]};
      if (n || (i && z)) begin r = 32'h7FC00000; f = {i && z, 3'b000}; end
      else if (i)        begin r = {sg, 8'hFF, 23'd0}; f = 4'b0000; end
      else if (z)        begin r = {sg, 31'd0}; f = 4'b0000; end
      else if (e >= 255) begin r = {sg, 8'hFF, 23'd0}; f = 4'b0101; end
      else if (epre <= 0) begin r = {sg, 31'd0}; f = 4'b0011; end
      return {f, r};
   endfunction

   // Scoreboard: record each accepted input, compare each delivered output
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("sb_unexpected", {31'd0, out_valid}, 32'd0);
            else begin
               mon_e = q.pop_front();
               chk("sb_result", result, mon_e[31:0]);
               chk("sb_flags", {28'd0, flags}, {28'd0, mon_e[35:32]});
            end
         end
         if (in_valid && in_ready)
            q.push_back(model(prod, sign, exp_sum, op_zero, op_inf, op_nan));
      end
   end

   task automatic put(input logic [49:0] p, input logic sg, input logic [9:0] es,
                      input logic z, input logic i, input logic n);
      prod = p; sign = sg; exp_sum = es; op_zero = z; op_inf = i; op_nan = n;
      in_valid = 1'b1;
   endtask

   // One isolated transaction: latency counted in clock edges from the transfer
   task automatic dir(input string tag, input logic [49:0] p, input logic sg,
                      input logic [9:0] es, input logic z, input logic i,
                      input logic n, input logic [31:0] er, input logic [3:0] ef);
      int cyc;
      out_ready = 1'b1;
      put(p, sg, es, z, i, n);
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 8) begin @(posedge clk); #1; cyc++; end
      chk({tag, "_lat"}, 32'(cyc), 32'd2);
      chk({tag, "_res"}, result, er);
      chk({tag, "_flg"}, {28'd0, flags}, {28'd0, ef});
   endtask

   task automatic rnd_put();
      logic [49:0] p;
      logic [9:0]  es;
      p = 50'({$urandom, $urandom});
      if ($urandom_range(1) == 1) p[49] = 1'b1;
      else p[49:48] = 2'b01;
      if ($urandom_range(3) == 0) p[23:0] = 24'd0;
      if ($urandom_range(7) == 0) p[47:25] = 23'h7FFFFF;
      case ($urandom_range(3))
         0:       es = 10'($urandom_range(510));
         1:       es = 10'($urandom_range(140, 110));
         2:       es = 10'($urandom_range(390, 370));
         default: es = 10'($urandom_range(300, 180));
      endcase
      put(p, 1'($urandom), es, $urandom_range(9) == 0, $urandom_range(9) == 0,
          $urandom_range(9) == 0);
   endtask

   localparam logic [49:0] ONE   = 50'h1_0000_0000_0000;
   localparam logic [49:0] P225  = 50'h2_4000_0000_0000;
   localparam logic [49:0] G     = 50'h0_0000_0100_0000;
   localparam logic [49:0] M0    = 50'h0_0000_0200_0000;
   localparam logic [49:0] MALL  = 50'h0_FFFF_FE00_0000;

   initial begin
      logic took;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; prod = '0; sign = 1'b0;
      exp_sum = '0; op_zero = 1'b0; op_inf = 1'b0; op_nan = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ov", {31'd0, out_valid}, 32'd0);
      chk("rst_res", result, 32'd0);
      chk("rst_flg", {28'd0, flags}, 32'd0);
      rst = 1'b0;
      #1 chk("rst_rdy", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;

      // Directed corners
      dir("one",      ONE,           0, 254, 0, 0, 0, 32'h3F800000, 4'b0000);
      dir("p225",     P225,          0, 254, 0, 0, 0, 32'h40100000, 4'b0000);
      dir("tie_even", ONE | G,       0, 254, 0, 0, 0, 32'h3F800000, 4'b0001);
      dir("tie_odd",  ONE | M0 | G,  0, 254, 0, 0, 0, 32'h3F800002, 4'b0001);
      dir("carry",    ONE | MALL | G, 0, 254, 0, 0, 0, 32'h40000000, 4'b0001);
      dir("ovf",      ONE,           0, 400, 0, 0, 0, 32'h7F800000, 4'b0101);
      dir("unf",      ONE,           0, 100, 0, 0, 0, 32'h00000000, 4'b0011);
      dir("inf_zero", ONE,           0, 254, 1, 1, 0, 32'h7FC00000, 4'b1000);
      dir("nan",      ONE,           1, 254, 0, 0, 1, 32'h7FC00000, 4'b0000);
      dir("inf",      ONE,           1, 254, 0, 1, 0, 32'hFF800000, 4'b0000);
      dir("zero",     ONE,           1, 254, 1, 0, 0, 32'h80000000, 4'b0000);
      dir("e254",     ONE,           0, 381, 0, 0, 0, 32'h7F000000, 4'b0000);
      dir("carry_ovf", ONE | MALL | G, 1, 381, 0, 0, 0, 32'hFF800000, 4'b0101);
      dir("carry_e0", ONE | MALL | G, 1, 127, 0, 0, 0, 32'h80000000, 4'b0011);

      // Backpressure: two accepted, third blocked, outputs hold, then drain
      @(posedge clk); #1;
      out_ready = 1'b0;
      put(ONE, 1, 254, 0, 0, 0);
      @(negedge clk) chk("bp_rdy0", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      put(P225, 0, 254, 0, 0, 0);
      @(negedge clk) chk("bp_rdy1", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      put(ONE, 0, 200, 0, 0, 0);
      @(negedge clk) chk("bp_rdy2", {31'd0, in_ready}, 32'd0);
      held = result;
      chk("bp_first", held, 32'hBF800000);
      repeat (3) begin
         @(posedge clk); #1;
         chk("bp_hold", result, held);
         chk("bp_ov", {31'd0, out_valid}, 32'd1);
         chk("bp_stall", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain0_v", {31'd0, out_valid}, 32'd1);
      chk("drain0_r", result, 32'hBF800000);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain1_v", {31'd0, out_valid}, 32'd1);
      chk("drain1_r", result, 32'h40100000);
      @(negedge clk);
      chk("drain2_v", {31'd0, out_valid}, 32'd1);
      chk("drain2_r", result, 32'h24800000);
      @(negedge clk);
      chk("drain3_v", {31'd0, out_valid}, 32'd0);

      // Reset with both stages occupied
      @(posedge clk); #1;
      out_ready = 1'b0;
      put(ONE, 0, 254, 0, 0, 0);
      @(posedge clk); #1;
      put(P225, 0, 254, 0, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst = 1'b1;
      q.delete();
      #1;
      chk("rstmid_ov", {31'd0, out_valid}, 32'd0);
      chk("rstmid_res", result, 32'd0);
      chk("rstmid_flg", {28'd0, flags}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(negedge clk) chk("rst_stale", {31'd0, out_valid}, 32'd0);
      end
      @(posedge clk); #1;

      // Randomized traffic with random backpressure
      for (int k = 0; k < 600; k++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took || !in_valid) begin
            if ($urandom_range(3) != 0) rnd_put();
            else in_valid = 1'b0;
         end
         out_ready = ($urandom_range(3) != 0);
      end
      out_ready = 1'b1;
      for (int k = 0; k < 20 && in_valid; k++) begin
         @(negedge clk);
         took = in_valid && in_ready;
         @(posedge clk); #1;
         if (took) in_valid = 1'b0;
      end
      repeat (6) @(posedge clk);
      #1;
      chk("sb_drain", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
